// File: rtl/xcvr_user_fifo_pkg.sv
// =============================================================================
// Module : xcvr_user_fifo_pkg
// Desc   : Shared widths, packer state encoding and saturating-increment helper
//          for the transceiver user FIFO interconnect.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package xcvr_user_fifo_pkg;

    localparam int IN_W_DEF  = 64;
    localparam int OUT_W_DEF = 128;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        LOW       = 2'd1,
        HIGH      = 2'd2
    } rx_pack_state_t;

    // Callers zero-extend their count and pass their own all-ones ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xcvr_sat_counter.sv
// =============================================================================
// Module : xcvr_sat_counter
// Desc   : Up-counter that sticks at all-ones; cleared only by reset.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module xcvr_sat_counter
    import xcvr_user_fifo_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt_d   = W'(sat_inc(32'(cnt_q), 32'(C_MAX)));
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/xcvr_user_rx_fifo_packer.sv
// =============================================================================
// Module : xcvr_user_rx_fifo_packer
// Desc   : Packs pairs of RX transceiver words (first word low) into FIFO-width
//          writes, dropping and counting writes while the FIFO is full.
//          Optional stats build: define XCVR_RX_PACKER_STATS_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module xcvr_user_rx_fifo_packer
    import xcvr_user_fifo_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  rx_data,
    input  logic             rx_valid,
    input  logic             rx_locked,
    input  logic             flush,
    output logic [OUT_W-1:0] data,
    output logic             wrreq,
    output logic             wrclk,
    input  logic             wrfull,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] words_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    rx_pack_state_t   state_q;
    rx_pack_state_t   state_d;
    logic [IN_W-1:0]  low_q;
    logic [IN_W-1:0]  low_d;
    logic [OUT_W-1:0] data_q;
    logic             wrreq_q;
    logic             overflow_q;

    logic             pack_fire;
    logic             lock_loss;
    logic             do_write;
    logic             do_drop;

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        pack_fire = 1'b0;
        lock_loss = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (rx_locked) begin
                    state_d = LOW;
                end
            end
            LOW, HIGH: begin
                if (!rx_locked) begin
                    state_d   = WAIT_LOCK;
                    lock_loss = 1'b1;
                end else if (flush) begin
                    state_d = LOW;
                end else if (rx_valid) begin
                    if (state_q == LOW) begin
                        low_d   = rx_data;
                        state_d = HIGH;
                    end else begin
                        pack_fire = 1'b1;
                        state_d   = LOW;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // The RX side cannot be stalled, so a full FIFO costs the whole packed word.
    assign do_write = pack_fire & ~wrfull;
    assign do_drop  = pack_fire &  wrfull;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_LOCK;
            low_q      <= '0;
            data_q     <= '0;
            wrreq_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            wrreq_q <= do_write;
            if (do_write) begin
                data_q <= {rx_data, low_q};
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign data     = data_q;
    assign wrreq    = wrreq_q;
    assign overflow = overflow_q;
    assign wrclk    = clk;

    xcvr_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (do_drop),
        .count_o (drop_cnt)
    );

`ifdef XCVR_RX_PACKER_STATS_EN
    xcvr_sat_counter #(.W(CNT_W)) u_words_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (do_write),
        .count_o (words_cnt)
    );

    xcvr_sat_counter #(.W(CNT_W)) u_lock_loss_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (lock_loss),
        .count_o (lock_loss_cnt)
    );
`else
    logic unused_lock_loss;
    assign unused_lock_loss = lock_loss;
    assign words_cnt        = '0;
    assign lock_loss_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xcvr_user_rx_fifo_packer.sv
// =============================================================================
// Module : tb_xcvr_user_rx_fifo_packer
// Desc   : Scoreboard bench for the RX FIFO packer (default and stats builds).
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_xcvr_user_rx_fifo_packer;

    localparam int IN_W  = 64;
    localparam int OUT_W = 128;
    localparam int CNT_W = 16;
`ifdef XCVR_RX_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  rx_data;
    logic             rx_valid;
    logic             rx_locked;
    logic             flush;
    logic [OUT_W-1:0] data;
    logic             wrreq;
    logic             wrclk;
    logic             wrfull;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] words_cnt;
    logic [CNT_W-1:0] lock_loss_cnt;

    xcvr_user_rx_fifo_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_locked     (rx_locked),
        .flush         (flush),
        .data          (data),
        .wrreq         (wrreq),
        .wrclk         (wrclk),
        .wrfull        (wrfull),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .words_cnt     (words_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [OUT_W-1:0] d;
        int               c;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    logic [IN_W-1:0]  m_low;
    bit               m_half;
    logic [CNT_W-1:0] m_drops;
    logic [CNT_W-1:0] m_words;
    logic [CNT_W-1:0] m_ll;

    function automatic logic [CNT_W-1:0] sinc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Every write strobe must match the oldest expected word at its expected cycle.
    always @(negedge clk) begin
        if (mon_en && wrreq !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_wrreq cyc=%0d got data=%h wrreq=%b expected no write", cyc, data, wrreq);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (data !== e.d || cyc != e.c) begin
                    failures++;
                    $display("FAIL write_data got data=%h cyc=%0d expected data=%h cyc=%0d", data, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_low   = '0;
        m_half  = 1'b0;
        m_drops = '0;
        m_words = '0;
        m_ll    = '0;
        sb.delete();
    endtask

    // Drive one valid word for one cycle and update the bench's pairing model.
    task automatic send(input logic [IN_W-1:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        if (m_half) begin
            if (!wrfull) begin
                sb.push_back('{d: {w, m_low}, c: cyc + 1});
                m_words = sinc(m_words);
            end else begin
                m_drops = sinc(m_drops);
            end
            m_half = 1'b0;
        end else begin
            m_low  = w;
            m_half = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding writes expected 0", name, sb.size());
        end
        checks++;
        if (drop_cnt !== m_drops || words_cnt !== (STATS ? m_words : '0) ||
            lock_loss_cnt !== (STATS ? m_ll : '0)) begin
            failures++;
            $display("FAIL %s_counters got drop=%h words=%h ll=%h expected drop=%h words=%h ll=%h",
                     name, drop_cnt, words_cnt, lock_loss_cnt, m_drops,
                     STATS ? m_words : '0, STATS ? m_ll : '0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_locked = 1'b0; flush = 1'b0;
        wrfull = 1'b0; rx_data = '0;
        repeat (2) tick();
        checks++;
        if (data !== '0 || wrreq !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0 ||
            words_cnt !== '0 || lock_loss_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h wrreq=%b ovf=%b drop=%h words=%h ll=%h expected all 0",
                     data, wrreq, overflow, drop_cnt, words_cnt, lock_loss_cnt);
        end
        @(negedge clk);
        checks++;
        if (wrclk !== clk) begin
            failures++;
            $display("FAIL wrclk got %b expected %b", wrclk, clk);
        end
        model_reset();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();
        rx_locked = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send(64'h1); send(64'h2); send(64'h3); send(64'h4);
        drain("basic");
    endtask

    task automatic test_gaps();
        send(64'h1); tick();
        send(64'h2); repeat (2) tick();
        send(64'h3); tick();
        send(64'h4);
        drain("gaps");
    endtask

    task automatic test_full();
        send(64'h11); send(64'h12);
        wrfull = 1'b1;
        send(64'h21); send(64'h22);
        wrfull = 1'b0;
        send(64'h31); send(64'h32);
        drain("full");
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got %b expected 1", overflow);
        end
    endtask

    task automatic test_lock_loss();
        send(64'hA);
        rx_locked = 1'b0;
        repeat (2) tick();
        m_half = 1'b0;
        m_ll   = sinc(m_ll);
        rx_locked = 1'b1;
        tick();
        send(64'hB); send(64'hC);
        drain("lock_loss");
    endtask

    task automatic test_flush();
        send(64'hD);
        flush    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 64'hE;
        tick();
        flush    = 1'b0;
        rx_valid = 1'b0;
        m_half   = 1'b0;
        send(64'hF); send(64'h10);
        drain("flush");
    endtask

    task automatic test_saturate_and_reset();
        dut.u_drop_cnt.cnt_q = 16'hFFFE;
        m_drops = 16'hFFFE;
        wrfull  = 1'b1;
        for (int i = 0; i < 6; i++) send(64'h100 + 64'(i));
        wrfull = 1'b0;
        drain("saturate");
        send(64'h55);
        reset = 1'b1;
        tick();
        sb.delete();
        checks++;
        if (data !== '0 || wrreq !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0 ||
            words_cnt !== '0 || lock_loss_cnt !== '0) begin
            failures++;
            $display("FAIL midpair_reset got data=%h wrreq=%b ovf=%b drop=%h words=%h ll=%h expected all 0",
                     data, wrreq, overflow, drop_cnt, words_cnt, lock_loss_cnt);
        end
        model_reset();
        reset = 1'b0;
        send(64'h66);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_full();
        test_lock_loss();
        test_flush();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
